ramb_asym_dp_sc: RTL and testbench
==================================

Name: ramb_asym_dp_sc

Overview:
Parametrised single-clock, true dual-port block RAM with asymmetric port widths: port A is WIDTH_A bits wide; port B is WIDTH_A<<RATIO_LOG2 bits wide. It is the next-generation block RAM model for the processor/peripheral memories.
Each port has a selectable write mode, a synchronous output set/reset value and an optional output pipeline register. The block also detects write-write collisions. It sits between the program/data memory users and their fabric, and is synthesisable as well as simulatable.

Parameters:
WIDTH_A, 8, port A data width in bits (1..32).
RATIO_LOG2, 1, log2 of the port B/A width ratio (0..3); WIDTH_B = WIDTH_A<<RATIO_LOG2.
ADDR_A_W, 9, port A address width; total bits = WIDTH_A*2^ADDR_A_W; ADDR_B_W = ADDR_A_W-RATIO_LOG2.
WRITE_MODE_A, 0, port A write mode: 0 WRITE_FIRST, 1 READ_FIRST, 2 NO_CHANGE.
WRITE_MODE_B, 0, port B write mode, same encoding as WRITE_MODE_A.
SRVAL_A, 0, value of DOA after async reset or sync RSTA (WIDTH_A bits).
SRVAL_B, 0, value of DOB after async reset or sync RSTB (WIDTH_B bits).
DO_REG, 0, output pipeline: 0 gives read latency 1; 1 adds an output register, giving latency 2.

Ports:
CLK  in  1  single clock for both ports, rising edge.
RST_N  in  1  asynchronous active-low reset.
ENA  in  1  port A enable.
WEA  in  1  port A write enable; qualified by ENA.
RSTA  in  1  port A synchronous output reset; qualified by ENA.
ADDRA  in  ADDR_A_W  port A word address.
DIA  in  WIDTH_A  port A write data.
DOA  out  WIDTH_A  port A read data.
ENB  in  1  port B enable.
WEB  in  1  port B write enable; qualified by ENB.
RSTB  in  1  port B synchronous output reset; qualified by ENB.
ADDRB  in  ADDR_B_W  port B word address.
DIB  in  WIDTH_B  port B write data.
DOB  out  WIDTH_B  port B read data.
COLL  out  1  registered write-write collision flag.

Behaviour:
- Bit mapping: A word i occupies mem[i*WIDTH_A +: WIDTH_A]; B word j occupies mem[j*WIDTH_B +: WIDTH_B]. B word j therefore holds A words j*R..j*R+R-1, with the lowest A address in the LSBs.
- Memory array is zero at time zero and is never affected by RST_N or RSTA/RSTB.
- RST_N low, asynchronous: DOA and the port A pipeline stage go to SRVAL_A; DOB and the port B pipeline stage go to SRVAL_B; COLL goes to 0. Writes are blocked while RST_N is low. Normal operation resumes on the first rising edge after release.
- EN=0 on a port: no write on that port, and its stage-1 output register holds.
- EN=1, RST=1: stage-1 output register loads SRVAL. A write requested in the same cycle (WE=1) still updates memory.
- EN=1, RST=0, WE=0: stage-1 loads mem[addr].
- EN=1, RST=0, WE=1: memory is written. Stage-1 then depends on the write mode:
  - WRITE_FIRST: stage-1 loads DI.
  - READ_FIRST: stage-1 loads the pre-write contents.
  - NO_CHANGE: stage-1 holds.
- DO_REG=0: DO = stage-1, so read latency is 1 cycle.
- DO_REG=1: stage-2 loads stage-1 every clock, unconditionally, and DO = stage-2. Read latency is 2 cycles, and RST/SRVAL effects also appear 2 cycles after the request.
- Cross-port read during write, same cycle, overlapping bits: the reading port returns the pre-write contents. COLL is not asserted.
- Write-write collision: ENA&WEA&ENB&WEB with (ADDRA>>RATIO_LOG2)==ADDRB.
  - Port B wins the overlapping A-word slice. The other slices of the B word take DIB as normal.
  - Each port's own output still follows its write mode. For example, WRITE_FIRST DOA shows DIA even though memory holds DIB's slice.
  - COLL is 1 on the cycle after the collision edge and returns to 0 the following cycle unless another collision occurs.
- Non-overlapping simultaneous writes both complete in the same cycle.
- Address wrap: none; every address value is in range by construction.
- Parameter checks (elaboration error):
  - RATIO_LOG2 > 3, or RATIO_LOG2 >= ADDR_A_W.
  - WRITE_MODE_A or WRITE_MODE_B outside 0..2.

Test Plan:
- Reset: hold RST_N=0 with SRVAL_A=8'hA5, SRVAL_B=16'h5A5A -> DOA=A5, DOB=5A5A, COLL=0 immediately (asynchronous) and while held. Then release and check the first read.
- Width mapping: write A[4]=8'h11 and A[5]=8'h22, then read B[2] -> DOB=16'h2211 one cycle later (two cycles with DO_REG=1). Write B[3]=16'hBEEF, read A[6]=EF and A[7]=BE.
- Write modes: prefill A[0]=8'h33, then write DIA=8'h44. WRITE_FIRST -> DOA=44; READ_FIRST -> DOA=33; NO_CHANGE -> DOA keeps its prior value. A following read returns 44 in all three modes.
- Sync reset with write: ENA=1, RSTA=1, WEA=1, DIA=8'h77 at A[9] -> DOA=SRVAL_A; a later read of A[9] returns 77. Repeat with ENA=0 -> no write and DOA holds.
- Collision: same edge, A[2]<=8'hAA and B[1]<=16'h1234 -> mem B[1]=16'h1234 and COLL=1 for exactly one cycle. Non-overlapping A[0] with B[1] -> both written, COLL=0.
- Cross-port read during write: B[0] holds 16'h0102; same edge, A writes A[0]<=8'hFF while B reads B[0] -> DOB=0102 this cycle and 01FF on the next read.

Source files
------------

// File: rtl/ramb_asym_dp_sc.sv
// Single-clock true dual-port block RAM with asymmetric port widths.
// Port B words are 2^RATIO_LOG2 port-A words packed with the lowest A address in the LSBs.

module ramb_asym_dp_sc_ostage #(
  parameter int            W      = 8,
  parameter int            MODE   = 0,
  parameter logic [W-1:0]  SRVAL  = '0,
  parameter int            DO_REG = 0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         en,
  input  logic         we,
  input  logic         rst,
  input  logic [W-1:0] di,
  input  logic [W-1:0] rd,
  output logic [W-1:0] dout
);
  logic [W-1:0] s1;

  // rd is the array contents sampled before this edge's write lands
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)             s1 <= SRVAL;
    else if (en) begin
      if (rst)              s1 <= SRVAL;
      else if (!we)         s1 <= rd;
      else if (MODE == 0)   s1 <= di;
      else if (MODE == 1)   s1 <= rd;
    end
  end

  generate
    if (DO_REG != 0) begin : g_reg
      logic [W-1:0] s2;
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) s2 <= SRVAL;
        else        s2 <= s1;
      end
      assign dout = s2;
    end else begin : g_noreg
      assign dout = s1;
    end
  endgenerate
endmodule

module ramb_asym_dp_sc #(
  parameter int                                 WIDTH_A      = 8,
  parameter int                                 RATIO_LOG2   = 1,
  parameter int                                 ADDR_A_W     = 9,
  parameter int                                 WRITE_MODE_A = 0,
  parameter int                                 WRITE_MODE_B = 0,
  parameter logic [WIDTH_A-1:0]                 SRVAL_A      = '0,
  parameter logic [(WIDTH_A<<RATIO_LOG2)-1:0]   SRVAL_B      = '0,
  parameter int                                 DO_REG       = 0
) (
  input  logic                                  CLK,
  input  logic                                  RST_N,
  input  logic                                  ENA,
  input  logic                                  WEA,
  input  logic                                  RSTA,
  input  logic [ADDR_A_W-1:0]                   ADDRA,
  input  logic [WIDTH_A-1:0]                    DIA,
  output logic [WIDTH_A-1:0]                    DOA,
  input  logic                                  ENB,
  input  logic                                  WEB,
  input  logic                                  RSTB,
  input  logic [ADDR_A_W-RATIO_LOG2-1:0]        ADDRB,
  input  logic [(WIDTH_A<<RATIO_LOG2)-1:0]      DIB,
  output logic [(WIDTH_A<<RATIO_LOG2)-1:0]      DOB,
  output logic                                  COLL
);
  localparam int R       = 1 << RATIO_LOG2;
  localparam int WIDTH_B = WIDTH_A << RATIO_LOG2;
  localparam int DEPTH   = 1 << ADDR_A_W;

  generate
    if (RATIO_LOG2 < 0 || RATIO_LOG2 > 3 || RATIO_LOG2 >= ADDR_A_W) begin : g_bad_ratio
      $error("ramb_asym_dp_sc: RATIO_LOG2 out of range");
    end
    if (WRITE_MODE_A < 0 || WRITE_MODE_A > 2 || WRITE_MODE_B < 0 || WRITE_MODE_B > 2) begin : g_bad_mode
      $error("ramb_asym_dp_sc: WRITE_MODE_A/B must be 0..2");
    end
  endgenerate

  logic [WIDTH_A-1:0]  mem [DEPTH] = '{default: '0};
  logic [ADDR_A_W-1:0] b_base;
  logic [WIDTH_B-1:0]  rd_b;
  logic [WIDTH_A-1:0]  rd_a;
  logic                coll_now;

  assign b_base = ADDR_A_W'(ADDRB) << RATIO_LOG2;
  assign rd_a   = mem[ADDRA];

  generate
    for (genvar k = 0; k < R; k++) begin : g_rdb
      assign rd_b[k*WIDTH_A +: WIDTH_A] = mem[b_base | ADDR_A_W'(k)];
    end
  endgenerate

  // B's write is issued after A's, so B owns the shared slice on a collision
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      if (ENA && WEA) mem[ADDRA] <= DIA;
      if (ENB && WEB)
        for (int k = 0; k < R; k++)
          mem[b_base | ADDR_A_W'(k)] <= DIB[k*WIDTH_A +: WIDTH_A];
    end
  end

  assign coll_now = ENA && WEA && ENB && WEB && ((ADDRA >> RATIO_LOG2) == ADDR_A_W'(ADDRB));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) COLL <= 1'b0;
    else        COLL <= coll_now;
  end

  ramb_asym_dp_sc_ostage #(
    .W(WIDTH_A), .MODE(WRITE_MODE_A), .SRVAL(SRVAL_A), .DO_REG(DO_REG)
  ) u_oa (
    .CLK(CLK), .RST_N(RST_N), .en(ENA), .we(WEA), .rst(RSTA),
    .di(DIA), .rd(rd_a), .dout(DOA)
  );

  ramb_asym_dp_sc_ostage #(
    .W(WIDTH_B), .MODE(WRITE_MODE_B), .SRVAL(SRVAL_B), .DO_REG(DO_REG)
  ) u_ob (
    .CLK(CLK), .RST_N(RST_N), .en(ENB), .we(WEB), .rst(RSTB),
    .di(DIB), .rd(rd_b), .dout(DOB)
  );
endmodule

// File: tb/tb_ramb_asym_dp_sc.sv
// Scoreboard bench: three instances (WF/RF/NC write modes, the NC one with DO_REG=1)
// share one directed stimulus stream; expected stage-1 values are queued per edge.

module tb_ramb_asym_dp_sc;
  typedef struct packed {
    logic [15:0]      idx;
    logic [2:0][7:0]  ea;
    logic [2:0][15:0] eb;
    logic             coll;
  } item_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        ENA = 0, WEA = 0, RSTA = 0, ENB = 0, WEB = 0, RSTB = 0;
  logic [8:0]  ADDRA = '0;
  logic [7:0]  ADDRB = '0;
  logic [7:0]  DIA = '0;
  logic [15:0] DIB = '0;

  logic [7:0]  doa  [3];
  logic [15:0] dob  [3];
  logic        coll [3];

  int errors = 0;
  int checks = 0;
  item_t q[$];
  int vidx = 0;

  always #5 CLK = ~CLK;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      ramb_asym_dp_sc #(
        .WIDTH_A(8), .RATIO_LOG2(1), .ADDR_A_W(9),
        .WRITE_MODE_A(g), .WRITE_MODE_B(g),
        .SRVAL_A(8'hA5), .SRVAL_B(16'h5A5A),
        .DO_REG(g == 2 ? 1 : 0)
      ) u_dut (
        .CLK(CLK), .RST_N(RST_N),
        .ENA(ENA), .WEA(WEA), .RSTA(RSTA), .ADDRA(ADDRA), .DIA(DIA), .DOA(doa[g]),
        .ENB(ENB), .WEB(WEB), .RSTB(RSTB), .ADDRB(ADDRB), .DIB(DIB), .DOB(dob[g]),
        .COLL(coll[g])
      );
    end
  endgenerate

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic item_t rst_item(input int n);
    item_t it;
    it.idx  = 16'(n);
    it.ea   = {3{8'hA5}};
    it.eb   = {3{16'h5A5A}};
    it.coll = 1'b0;
    return it;
  endfunction

  task automatic vec(input logic ena_i, wea_i, rsta_i, input logic [8:0] aa, input logic [7:0] da,
                     input logic enb_i, web_i, rstb_i, input logic [7:0] ab, input logic [15:0] db,
                     input logic [7:0] a0, a1, a2, input logic [15:0] b0, b1, b2, input logic c);
    item_t it;
    ENA = ena_i; WEA = wea_i; RSTA = rsta_i; ADDRA = aa; DIA = da;
    ENB = enb_i; WEB = web_i; RSTB = rstb_i; ADDRB = ab; DIB = db;
    @(posedge CLK);
    vidx++;
    it.idx  = 16'(vidx);
    it.ea   = {a2, a1, a0};
    it.eb   = {b2, b1, b0};
    it.coll = c;
    q.push_back(it);
    #1;
  endtask

  // Instance 2 has one extra cycle of latency, so it is checked against the previous item
  initial begin : monitor
    item_t cur, prev;
    prev = rst_item(0);
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        cur = q.pop_front();
        for (int g = 0; g < 2; g++) begin
          chk($sformatf("v%0d doa%0d", cur.idx, g), {8'h0, doa[g]}, {8'h0, cur.ea[g]});
          chk($sformatf("v%0d dob%0d", cur.idx, g), dob[g], cur.eb[g]);
        end
        chk($sformatf("v%0d doa2", cur.idx), {8'h0, doa[2]}, {8'h0, prev.ea[2]});
        chk($sformatf("v%0d dob2", cur.idx), dob[2], prev.eb[2]);
        for (int g = 0; g < 3; g++)
          chk($sformatf("v%0d coll%0d", cur.idx, g), {15'h0, coll[g]}, {15'h0, cur.coll});
        prev = cur;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    #2 RST_N = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("async_rst doa%0d", g), {8'h0, doa[g]}, 16'h00A5);
      chk($sformatf("async_rst dob%0d", g), dob[g], 16'h5A5A);
      chk($sformatf("async_rst coll%0d", g), {15'h0, coll[g]}, 16'h0);
    end
    repeat (2) begin
      @(posedge CLK);
      q.push_back(rst_item(0));
      #1;
    end
    RST_N = 1'b1;
    //   ENA WEA RSTA ADDRA DIA   ENB WEB RSTB ADDRB DIB        A:WF  RF    NC     B:WF      RF        NC     COLL
    vec(1,0,0, 9'd0,  8'h00, 1,0,0, 8'd0, 16'h0000, 8'h00,8'h00,8'h00, 16'h0000,16'h0000,16'h0000, 0);
    vec(1,1,0, 9'd4,  8'h11, 0,0,0, 8'd0, 16'h0000, 8'h11,8'h00,8'h00, 16'h0000,16'h0000,16'h0000, 0);
    vec(1,1,0, 9'd5,  8'h22, 0,0,0, 8'd0, 16'h0000, 8'h22,8'h00,8'h00, 16'h0000,16'h0000,16'h0000, 0);
    vec(0,0,0, 9'd0,  8'h00, 1,0,0, 8'd2, 16'h0000, 8'h22,8'h00,8'h00, 16'h2211,16'h2211,16'h2211, 0);
    vec(0,0,0, 9'd0,  8'h00, 1,1,0, 8'd3, 16'hBEEF, 8'h22,8'h00,8'h00, 16'hBEEF,16'h0000,16'h2211, 0);
    vec(1,0,0, 9'd6,  8'h00, 0,0,0, 8'd0, 16'h0000, 8'hEF,8'hEF,8'hEF, 16'hBEEF,16'h0000,16'h2211, 0);
    vec(1,0,0, 9'd7,  8'h00, 0,0,0, 8'd0, 16'h0000, 8'hBE,8'hBE,8'hBE, 16'hBEEF,16'h0000,16'h2211, 0);
    vec(1,1,0, 9'd0,  8'h33, 0,0,0, 8'd0, 16'h0000, 8'h33,8'h00,8'hBE, 16'hBEEF,16'h0000,16'h2211, 0);
    vec(1,1,0, 9'd0,  8'h44, 0,0,0, 8'd0, 16'h0000, 8'h44,8'h33,8'hBE, 16'hBEEF,16'h0000,16'h2211, 0);
    vec(1,0,0, 9'd0,  8'h00, 0,0,0, 8'd0, 16'h0000, 8'h44,8'h44,8'h44, 16'hBEEF,16'h0000,16'h2211, 0);
    vec(1,1,1, 9'd9,  8'h77, 0,0,0, 8'd0, 16'h0000, 8'hA5,8'hA5,8'hA5, 16'hBEEF,16'h0000,16'h2211, 0);
    vec(1,0,0, 9'd9,  8'h00, 0,0,0, 8'd0, 16'h0000, 8'h77,8'h77,8'h77, 16'hBEEF,16'h0000,16'h2211, 0);
    vec(0,1,1, 9'd10, 8'h99, 0,0,0, 8'd0, 16'h0000, 8'h77,8'h77,8'h77, 16'hBEEF,16'h0000,16'h2211, 0);
    vec(1,0,0, 9'd10, 8'h00, 0,0,0, 8'd0, 16'h0000, 8'h00,8'h00,8'h00, 16'hBEEF,16'h0000,16'h2211, 0);
    vec(0,0,0, 9'd0,  8'h00, 1,0,1, 8'd3, 16'h0000, 8'h00,8'h00,8'h00, 16'h5A5A,16'h5A5A,16'h5A5A, 0);
    vec(1,1,0, 9'd2,  8'hAA, 1,1,0, 8'd1, 16'h1234, 8'hAA,8'h00,8'h00, 16'h1234,16'h0000,16'h5A5A, 1);
    vec(1,0,0, 9'd2,  8'h00, 1,0,0, 8'd1, 16'h0000, 8'h34,8'h34,8'h34, 16'h1234,16'h1234,16'h1234, 0);
    vec(1,1,0, 9'd0,  8'h55, 1,1,0, 8'd1, 16'h5678, 8'h55,8'h44,8'h34, 16'h5678,16'h1234,16'h1234, 0);
    vec(1,0,0, 9'd0,  8'h00, 1,0,0, 8'd1, 16'h0000, 8'h55,8'h55,8'h55, 16'h5678,16'h5678,16'h5678, 0);
    vec(0,0,0, 9'd0,  8'h00, 1,1,0, 8'd0, 16'h0102, 8'h55,8'h55,8'h55, 16'h0102,16'h0055,16'h5678, 0);
    vec(1,1,0, 9'd0,  8'hFF, 1,0,0, 8'd0, 16'h0000, 8'hFF,8'h02,8'h55, 16'h0102,16'h0102,16'h0102, 0);
    vec(0,0,0, 9'd0,  8'h00, 1,0,0, 8'd0, 16'h0000, 8'hFF,8'h02,8'h55, 16'h01FF,16'h01FF,16'h01FF, 0);
    vec(1,1,0, 9'd6,  8'hAB, 1,1,0, 8'd3, 16'hCDEF, 8'hAB,8'hEF,8'h55, 16'hCDEF,16'hBEEF,16'h01FF, 1);
    vec(1,1,0, 9'd7,  8'h12, 1,1,0, 8'd3, 16'h3456, 8'h12,8'hCD,8'h55, 16'h3456,16'hCDEF,16'h01FF, 1);
    vec(1,0,0, 9'd7,  8'h00, 1,0,0, 8'd3, 16'h0000, 8'h34,8'h34,8'h34, 16'h3456,16'h3456,16'h3456, 0);
    vec(0,0,0, 9'd0,  8'h00, 0,0,0, 8'd0, 16'h0000, 8'h34,8'h34,8'h34, 16'h3456,16'h3456,16'h3456, 0);
    repeat (2) @(posedge CLK);
    #1;
    chk("queue_drained", 16'(q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
